// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the I/D main-memory arbiter.
//   arb_state_t    : arbiter FSM states
//   arb_side_t     : requester identity (used by the round-robin history)
//   mem_wr_t       : latched write-through store payload
//   WORDS_PER_LINE : words per cache line (16-bit words, 16-byte line)
//   MEM_LAT        : main-memory read latency, address issue to mem_valid
//   LINE_MASK      : clears the byte offset within a line
package mem_arb_pkg;

    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned MEM_LAT        = 4;
    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned IDX_W          = $clog2(WORDS_PER_LINE);
    // One extra bit so the counters can hold WORDS_PER_LINE and saturate there.
    localparam int unsigned CNT_W          = IDX_W + 1;

    localparam logic [ADDR_W-1:0] LINE_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_wr_t;

    // Line-aligned base address of any address within the line.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_line_fill_counter.sv
// line_fill_counter: issue/receive bookkeeping for one cache-line fill.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : start a new fill; latches line base, zeroes both counters
//   active        : a fill state is current
//   base_in       : any address inside the line to be filled
//   mem_valid     : main-memory read data is valid this cycle
//   issue_vld_c   : issue a read this cycle
//   issue_addr_c  : address of the read being issued
//   recv_vld_c    : accept the returning word this cycle
//   recv_last_c   : the accepted word is the final word of the line
//   recv_idx      : word index of the next word to be accepted
module line_fill_counter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              active,
    input  logic [ADDR_W-1:0] base_in,
    input  logic              mem_valid,
    output logic              issue_vld_c,
    output logic [ADDR_W-1:0] issue_addr_c,
    output logic              recv_vld_c,
    output logic              recv_last_c,
    output logic [IDX_W-1:0]  recv_idx
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_LINE - 1);

    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  recv_cnt_q,  recv_cnt_d;
    logic [ADDR_W-1:0] base_q,      base_d;

    // Counters stop at CNT_FULL, so late or stray mem_valid pulses are dropped.
    assign issue_vld_c  = active && (issue_cnt_q < CNT_FULL);
    assign issue_addr_c = base_q + ADDR_W'({issue_cnt_q, 1'b0});
    assign recv_vld_c   = active && mem_valid && (recv_cnt_q < CNT_FULL);
    assign recv_last_c  = recv_vld_c && (recv_cnt_q == CNT_LAST);
    assign recv_idx     = recv_cnt_q[IDX_W-1:0];

    // Next-state for base and counters.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        base_d      = base_q;
        if (clear) begin
            base_d      = line_base(base_in);
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
        end else begin
            if (issue_vld_c) begin
                issue_cnt_d = issue_cnt_q + CNT_W'(1);
            end
            if (recv_vld_c) begin
                recv_cnt_d = recv_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one multi-cycle main memory between the I-cache
// and D-cache miss handlers. Runs 8-word line fills or single-word stores.
//   clk, rst                     : clock, synchronous active-high reset
//   i_req, i_addr                : I-side line-fill request
//   d_req, d_we, d_addr, d_wdata : D-side fill (d_we=0) or store (d_we=1)
//   fill_data, fill_idx          : returned word and its index in the line
//   i_fill_valid, d_fill_valid   : fill word valid for the I / D side
//   i_done, d_done               : one-cycle end-of-transaction strobes
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                    : main-memory command
//   mem_rdata, mem_valid         : main-memory read return
// Build macros:
//   ARB_RR_EN     : round-robin arbitration when both sides request
//                   (default: D side always wins)
//   MEM_ARB_DEBUG : flag mem_valid pulses that arrive outside a fill
module mem_access_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] fill_data,
    output logic [IDX_W-1:0]  fill_idx,
    output logic              i_fill_valid,
    output logic              d_fill_valid,
    output logic              i_done,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    arb_state_t state_q, state_d;
    mem_wr_t    wr_q,    wr_d;
`ifdef ARB_RR_EN
    arb_side_t  rr_last_q, rr_last_d;
`endif

    logic              pick_d;
    logic              pick_i;
    logic              fill_clear;
    logic              in_fill;
    logic              in_write;
    logic              issue_vld_c;
    logic [ADDR_W-1:0] issue_addr_c;
    logic              recv_vld_c;
    logic              recv_last_c;
    logic [IDX_W-1:0]  recv_idx;

    // Grant selection; only acted on in IDLE.
    always_comb begin
`ifdef ARB_RR_EN
        pick_d = d_req && (!i_req || (rr_last_q == SIDE_I));
`else
        pick_d = d_req;
`endif
        pick_i = i_req && !pick_d;
    end

    // FSM next-state, store latch and grant history.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        fill_clear = 1'b0;
`ifdef ARB_RR_EN
        rr_last_d  = rr_last_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d) begin
`ifdef ARB_RR_EN
                    rr_last_d = SIDE_D;
`endif
                    if (d_we) begin
                        state_d = D_WRITE;
                        wr_d    = '{addr: d_addr, data: d_wdata};
                    end else begin
                        state_d    = D_FILL;
                        fill_clear = 1'b1;
                    end
                end else if (pick_i) begin
`ifdef ARB_RR_EN
                    rr_last_d  = SIDE_I;
`endif
                    state_d    = I_FILL;
                    fill_clear = 1'b1;
                end
            end
            I_FILL, D_FILL: begin
                if (recv_last_c) begin
                    state_d = IDLE;
                end
            end
            D_WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_q      <= '0;
`ifdef ARB_RR_EN
            rr_last_q <= SIDE_I;
`endif
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
`ifdef ARB_RR_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    assign in_fill  = (state_q == I_FILL) || (state_q == D_FILL);
    assign in_write = (state_q == D_WRITE);

    line_fill_counter u_fill_cnt (
        .clk          (clk),
        .rst          (rst),
        .clear        (fill_clear),
        .active       (in_fill),
        .base_in      (pick_d ? d_addr : i_addr),
        .mem_valid    (mem_valid),
        .issue_vld_c  (issue_vld_c),
        .issue_addr_c (issue_addr_c),
        .recv_vld_c   (recv_vld_c),
        .recv_last_c  (recv_last_c),
        .recv_idx     (recv_idx)
    );

    // Memory command decoded from state and counter registers only.
    assign mem_en    = issue_vld_c || in_write;
    assign mem_wr    = in_write;
    assign mem_addr  = in_write ? wr_q.addr : (issue_vld_c ? issue_addr_c : '0);
    assign mem_wdata = in_write ? wr_q.data : '0;

    // Fill return is steered in the cycle the word arrives.
    assign fill_data    = recv_vld_c ? mem_rdata : '0;
    assign fill_idx     = recv_idx;
    assign i_fill_valid = recv_vld_c && (state_q == I_FILL);
    assign d_fill_valid = recv_vld_c && (state_q == D_FILL);
    assign i_done       = recv_last_c && (state_q == I_FILL);
    assign d_done       = (recv_last_c && (state_q == D_FILL)) || in_write;

    // A requester must hold its request until its done strobe.
    a_i_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == I_FILL) |-> i_req);
    a_d_req_held: assert property (@(posedge clk) disable iff (rst)
        ((state_q == D_FILL) || (state_q == D_WRITE)) |-> d_req);

`ifdef MEM_ARB_DEBUG
    a_no_stray_valid: assert property (@(posedge clk) disable iff (rst)
        mem_valid |-> recv_vld_c);
`endif

endmodule
